vga_frame_reader: RTL and testbench

//   Read side of the VGA framebuffer RAM. Generates 640x480@60 VGA timing from
//   the system clock using a pixel-tick divider. Walks the framebuffer address
//   in raster order and drives the RAM with wEn held low. Registers the returned

---
 rtl/vga_frame_reader.sv | 136 +++++++++++++
 tb/tb_vga_frame_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// ============================================================================
// Module      : vga_frame_reader
// Description : VGA timing generator and framebuffer read pipeline feeding the
//               colour/DAC stage with pixel data aligned to hSync/vSync/active.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 19,
  parameter int CLK_DIV       = 4,
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_wEn,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    pixel_out,
  output logic                     hSync,
  output logic                     vSync,
  output logic                     active,
  output logic                     frame_start
);

  localparam int c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_DIV_W    = $clog2(CLK_DIV);
  localparam int c_H_W      = $clog2(c_H_TOTAL);
  localparam int c_V_W      = $clog2(c_V_TOTAL);
  localparam int c_HS_START = H_VISIBLE + H_FRONT;
  localparam int c_VS_START = V_VISIBLE + V_FRONT;

  logic [c_DIV_W-1:0]       r_div;
  logic [c_H_W-1:0]         r_h;
  logic [c_V_W-1:0]         r_v;
  logic [ADDRESS_WIDTH-1:0] r_run_addr;
  logic                     r_vis_d;
  logic                     r_hs_d;
  logic                     r_vs_d;

  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_vis;
  logic w_hs_raw;
  logic w_vs_raw;

  assign w_tick   = (r_div == c_DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h == c_H_W'(c_H_TOTAL - 1));
  assign w_v_last = (r_v == c_V_W'(c_V_TOTAL - 1));
  assign w_vis    = (32'(r_h) < H_VISIBLE) && (32'(r_v) < V_VISIBLE);
  assign w_hs_raw = !((32'(r_h) >= c_HS_START) && (32'(r_h) < c_HS_START + H_SYNC));
  assign w_vs_raw = !((32'(r_v) >= c_VS_START) && (32'(r_v) < c_VS_START + V_SYNC));
  assign ram_wEn  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Stage 1: address issue. The running address replaces a v*H_VISIBLE+h multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr   <= '0;
      r_run_addr <= '0;
      r_vis_d    <= 1'b0;
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
    end else if (w_tick) begin
      r_vis_d <= w_vis;
      r_hs_d  <= w_hs_raw;
      r_vs_d  <= w_vs_raw;
      if (w_vis) begin
        ram_addr   <= r_run_addr;
        r_run_addr <= r_run_addr + 1'b1;
      end
      if (w_h_last && w_v_last) begin
        r_run_addr <= '0;
      end
    end
  end

  // Stage 2: RAM data has had at least one clk to settle since the address changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out <= '0;
      active    <= 1'b0;
      hSync     <= 1'b1;
      vSync     <= 1'b1;
    end else if (w_tick) begin
      pixel_out <= r_vis_d ? ram_data : '0;
      active    <= r_vis_d;
      hSync     <= r_hs_d;
      vSync     <= r_vs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_tick && (r_h == '0) && (r_v == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
// ============================================================================
// Module      : tb_vga_frame_reader
// Description : Randomized scoreboard bench for vga_frame_reader on a reduced
//               raster, with random RAM contents and random mid-frame resets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_reader;

  localparam int D  = 3;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int AW = 6;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] pix;
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic          ram_wEn;
  logic [DW-1:0] ram_data = '0;
  logic [DW-1:0] pixel_out;
  logic          hSync, vSync, active, frame_start;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            force_ff;
  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            n = 0;

  vga_frame_reader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CLK_DIV(D),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .ram_addr(ram_addr), .ram_wEn(ram_wEn),
    .ram_data(ram_data), .pixel_out(pixel_out), .hSync(hSync), .vSync(vSync),
    .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM with one clk read latency
  always @(posedge clk) ram_data <= force_ff ? 8'hFF : mem[ram_addr];

  function automatic logic [DW-1:0] pix_of(int a);
    return force_ff ? 8'hFF : mem[a];
  endfunction

  // Expected outputs after the n-th clk edge since the reset edge (n=0 is the reset edge)
  function automatic exp_t model(int edges);
    exp_t e;
    int k, p, h, v;
    e.addr = '0; e.pix = '0; e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    if (edges < D) return e;
    k = edges / D - 1;
    p = k % FT;
    h = p % HT;
    v = p / HT;
    e.fs = (edges % D == 0) && (p == 0);
    if (v >= VV)      e.addr = AW'(VV * HV - 1);
    else if (h >= HV) e.addr = AW'(v * HV + HV - 1);
    else              e.addr = AW'(v * HV + h);
    if (k >= 1) begin
      p = (k - 1) % FT;
      h = p % HT;
      v = p / HT;
      e.act = (h < HV) && (v < VV);
      e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      e.pix = e.act ? pix_of(v * HV + h) : '0;
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
  endtask

  // Reference model: push the expected state for every clk edge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) n = 0;
      else n++;
      q.push_back(model(n));
    end
  end

  // Monitor: compare each registered state away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("ram_wEn", 32'(ram_wEn), 32'd0);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ram_addr",    32'(ram_addr),    32'(e.addr));
        check("pixel_out",   32'(pixel_out),   32'(e.pix));
        check("active",      32'(active),      32'(e.act));
        check("hSync",       32'(hSync),       32'(e.hs));
        check("vSync",       32'(vSync),       32'(e.vs));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    force_ff = 1'b0;
    fill_mem();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // First segment spans more than two frames to exercise address wrap
    repeat (2 * FT * D + 100) @(negedge clk);
    for (int seg = 0; seg < 12; seg++) begin
      reset    = 1'b1;
      force_ff = ($urandom_range(0, 2) == 0);
      fill_mem();
      repeat ($urandom_range(1, 2)) @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(20, 1200)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
